data_mem_ctrl: RTL
==================

# data_mem_ctrl

Data-memory controller between the RV32E load/store stage and the byte-lane data memory. It accepts byte, halfword and word requests at any byte address, including misaligned ones. It maps each request onto four byte-wide `memory_bank` lanes, one lane per byte, with a lane-specific row address. It returns little-endian, sign- or zero-extended load data through a registered, back-pressurable response port.

## Interface
- `DATA_DEPTH`, default 4096: rows per lane; total capacity is 4*DATA_DEPTH bytes.
- `BASE_ADDR`, default 32'h0000_0000: byte address of memory row 0, lane 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when both `req_valid` and `req_ready` are high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size (`mem_size_t`): 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads: zero-extend when high, sign-extend when low.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response held until `rsp_ready`.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and faults.
- `rsp_fault`  out  1  access was rejected.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - ACCESS: bank read in flight; `req_ready`=0.
  - RESP: `rsp_valid`=1; `req_ready`=`rsp_ready`.
- Transitions:
  - IDLE or RESP, on accept -> ACCESS.
  - ACCESS -> RESP, unconditionally.
  - RESP, on `rsp_ready` with no new accept -> IDLE.
- Address decode:
  - Effective address: eff = `req_addr` - `BASE_ADDR`; n = 1, 2 or 4 bytes.
  - offset = eff[1:0]; row = eff >> 2.
  - Lane i row address = row + (i < offset ? 1 : 0).
  - Request byte k goes to lane (offset+k) mod 4, for k < n.
- Fault conditions:
  - `req_size`=11, or eff + n - 1 >= 4*DATA_DEPTH (computed at 33 bits; address wrap or underflow faults).
  - On fault: no lane written; `rsp_fault`=1 and `rsp_rdata`=0 at normal latency.
  - Misalignment is not a fault.
- Stores:
  - Lane write enables are driven only in the accept cycle, only for lanes touched by the request, and only when the request has no fault.
  - Lane write data is `req_wdata` byte k.
- Loads:
  - offset, size and unsigned are registered at accept.
  - In ACCESS, byte k is taken from lane (offset+k) mod 4, assembled little-endian, extended to 32 bits, and registered into `rsp_rdata`.
- Store response: `rsp_fault` as computed; `rsp_rdata`=0.
- Memory contents are never cleared by reset.

## Timing
- Accept in cycle T; the store write happens on the edge ending T.
- `rsp_valid` rises at T+2 (latency 2 for loads and stores).
- Back-to-back: a RESP-cycle handshake with a same-cycle accept gives one response every 2 cycles.
- Back-pressure: while `rsp_ready`=0 in RESP, `rsp_rdata` and `rsp_fault` stay stable and `req_ready`=0.
- Read-after-write: a load accepted at or after T+1 observes the store accepted at T.
- Reset values: state IDLE; `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0.
- While `rst` is high, `req_ready`=0 and all lane write enables are 0.
- Reset during ACCESS or RESP discards the in-flight response; a store already written stays written.

## Structure
- Package `mem_pkg` holds:
  - `mem_size_t` enum: MEM_BYTE, MEM_HALF, MEM_WORD, MEM_ILLEGAL.
  - `dmc_state_t` enum: IDLE, ACCESS, RESP.
  - Byte-lane count constant `NUM_LANES`=4.
- Sub-module: four instances of `memory_bank` with DATA_DEPTH passed through, generated per lane.
- Lane-address and lane-select logic stays inside this block.

## Test plan
- Word store at 0x100 of 0xDEADBEEF, then a signed byte load at 0x101 -> `rsp_rdata`=0xFFFFFFBE; the same load unsigned -> 0x000000BE; a signed half load at 0x102 -> 0xFFFFDEAD.
- Misaligned word store at 0x103 of 0x11223344, then a word load at 0x103 -> 0x11223344; a byte load at 0x104 -> 0x00000033; word at 0x100 unchanged except byte 0x103 = 0x44.
- With DATA_DEPTH=4096: a half load at 0x3FFE returns data with `rsp_fault`=0; a word load at 0x3FFE -> `rsp_fault`=1, `rsp_rdata`=0; a word store at 0x3FFE leaves 0x3FFE/0x3FFF unchanged; `req_size`=11 -> fault.
- Hold `rsp_ready`=0 for 3 cycles after `rsp_valid` -> response stable and `req_ready`=0 throughout; release -> a new request is accepted in the same cycle.
- `req_valid` and `rsp_ready` held high for 8 loads -> `rsp_valid` pulses every 2nd cycle, each 2 cycles after its accept, with data in order.
- Accept a load at T and assert `rst` at T+1 -> `rsp_valid` stays 0, FSM returns to IDLE, and memory contents are preserved on a subsequent load.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory controller: access sizes,
// controller states, lane count and load-data extension.
package mem_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } dmc_state_t;

    // Bytes touched by an access; illegal sizes report 4 but are always faulted.
    function automatic logic [2:0] size_bytes(input mem_size_t size);
        case (size)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input mem_size_t   size,
                                                input logic        is_unsigned);
        case (size)
            MEM_BYTE: return is_unsigned ? {24'd0, raw[7:0]}
                                         : {{24{raw[7]}}, raw[7:0]};
            MEM_HALF: return is_unsigned ? {16'd0, raw[15:0]}
                                         : {{16{raw[15]}}, raw[15:0]};
            default:  return raw;
        endcase
    endfunction

endpackage

// File: rtl/memory_bank.sv
// One byte-wide lane of data memory: synchronous write, registered
// read-before-write output, both qualified by en.
module memory_bank #(
    parameter int DATA_DEPTH = 4096,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DATA_DEPTH];

    // NOTE: the array has no reset on purpose; contents must survive rst and a
    // reset branch here would also block inference of a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store data-memory controller: splits byte/half/word requests at any
// byte address across four byte lanes and returns extended load data.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int          DATA_DEPTH = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int          ROW_W    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [32:0] CAPACITY = 33'(NUM_LANES * DATA_DEPTH);

    dmc_state_t state, state_next;
    logic       accept;

    mem_size_t        size_in;
    logic [31:0]      eff;
    logic [2:0]       nbytes;
    logic [32:0]      last_byte;
    logic             fault_in;
    logic [1:0]       offset;
    logic [ROW_W-1:0] row;

    logic             lane_we    [NUM_LANES];
    logic [7:0]       lane_wdata [NUM_LANES];
    logic [7:0]       lane_rdata [NUM_LANES];

    logic [1:0] off_q;
    mem_size_t  size_q;
    logic       uns_q;
    logic       fault_q;
    logic       we_q;
    logic [31:0] raw_load;

    // ---------------------------------------------------------------- control
    assign req_ready = !rst && ((state == IDLE) || (state == RESP && rsp_ready));
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // NOTE: state-holding blocks use non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
        if (accept) begin
            state_next = ACCESS;
        end
    end

    // ----------------------------------------------------------------- decode
    assign size_in   = mem_size_t'(req_size);
    assign eff       = req_addr - BASE_ADDR;
    assign nbytes    = size_bytes(size_in);
    // 33-bit end address so an access running past 2^32 cannot wrap into range.
    assign last_byte = {1'b0, eff} + 33'(nbytes) - 33'd1;
    assign fault_in  = (size_in == MEM_ILLEGAL) || (req_addr < BASE_ADDR) ||
                       (last_byte >= CAPACITY);
    assign offset    = eff[1:0];
    assign row       = eff[ROW_W+1:2];

    // ------------------------------------------------------------------ lanes
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [1:0]       k;
        logic [ROW_W-1:0] lane_row;

        // Request byte carried by this lane; lanes below the offset hold the
        // tail of a misaligned access and therefore sit one row further on.
        assign k              = 2'(i) - offset;
        assign lane_row       = row + ((2'(i) < offset) ? ROW_W'(1) : ROW_W'(0));
        assign lane_we[i]     = accept && req_we && !fault_in && ({1'b0, k} < nbytes);
        assign lane_wdata[i]  = req_wdata[8*k +: 8];

        memory_bank #(
            .DATA_DEPTH (DATA_DEPTH),
            .ADDR_W     (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (accept),
            .we    (lane_we[i]),
            .addr  (lane_row),
            .wdata (lane_wdata[i]),
            .rdata (lane_rdata[i])
        );
    end

    // --------------------------------------------------------------- response
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q   <= offset;
            size_q  <= size_in;
            uns_q   <= req_unsigned;
            fault_q <= fault_in;
            we_q    <= req_we;
        end
    end

    always_comb begin
        raw_load = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            raw_load[8*k +: 8] = lane_rdata[2'(off_q + 2'(k))];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_fault <= fault_q;
            rsp_rdata <= (fault_q || we_q) ? 32'd0 : extend_load(raw_load, size_q, uns_q);
        end
    end

endmodule
